// File: rtl/conv_row_read_ctrl.sv
// conv_row_read_ctrl
// Read scheduler between the PE output FIFO array and the row buffer of the
// last convolution stage. It reads the Wh FIFO rows one at a time and emits
// one Iw-element row vector per beat on a valid/ready stream. A 2-entry skid
// buffer absorbs the one-cycle FIFO read latency, and the controller counts
// lines so it can flag the final beat and pulse done at the end of the frame.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    frame start pulse (ignored unless idle)
//   pe2row_fifo_array1_rden  one-hot FIFO row read enable (same-cycle issue)
//   pe2row_ready             high while the controller is in RUN
//   fifo_array1_dataout      FIFO array read data, valid one cycle after rden
//   pe2row_data_valid        every FIFO row holds at least one vector
//   out_data/out_row/out_last/out_valid/out_ready  row vector stream
//   busy                     controller not idle
//   done                     one-cycle pulse at frame end
module conv_row_read_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned Wh          = 2,
  parameter int unsigned Iw          = 7,
  parameter int unsigned FRAME_LINES = 23,
  localparam int unsigned ROW_W      = (Wh > 1) ? $clog2(Wh) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [Wh-1:0]              pe2row_fifo_array1_rden,
  output logic                       pe2row_ready,
  input  logic [Wh*Iw*DATA_WIDTH-1:0] fifo_array1_dataout,
  input  logic                       pe2row_data_valid,
  output logic [Iw*DATA_WIDTH-1:0]   out_data,
  output logic [ROW_W-1:0]           out_row,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned VEC_W  = Iw * DATA_WIDTH;
  localparam int unsigned LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [VEC_W-1:0] data;
    logic [ROW_W-1:0] row;
    logic             last;
  } beat_t;

  state_t            state, state_nxt;
  logic [ROW_W-1:0]  row_idx;
  logic [LINE_W-1:0] line_cnt;
  logic [1:0]        occ;
  logic [1:0]        occ_nxt;
  logic              inflight;
  logic [ROW_W-1:0]  row_idx_d;
  logic              last_d;
  beat_t             head, tail;
  beat_t             cap;
  logic              pop;
  logic              issue;
  logic              final_rd;

  // Read issue, skid occupancy and next-state decode
  always_comb begin
    state_nxt = state;
    pop       = (occ != 2'd0) && out_ready;
    final_rd  = (row_idx == ROW_W'(Wh - 1)) && (line_cnt == LINE_W'(FRAME_LINES - 1));
    // A read may issue only if its data is guaranteed a skid slot next cycle
    issue     = !rst && (state == RUN) && pe2row_data_valid &&
                (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    occ_nxt   = occ + 2'(inflight) - 2'(pop);
    pe2row_fifo_array1_rden = issue ? (Wh'(1) << row_idx) : '0;
    cap.data  = fifo_array1_dataout[row_idx_d * VEC_W +: VEC_W];
    cap.row   = row_idx_d;
    cap.last  = last_d;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && final_rd) state_nxt = DRAIN;
      // No reads issue in DRAIN, so empty-after-this-cycle means fully drained
      DRAIN:   if (occ_nxt == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Counters, read tracking and skid buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx   <= '0;
      line_cnt  <= '0;
      occ       <= '0;
      inflight  <= 1'b0;
      row_idx_d <= '0;
      last_d    <= 1'b0;
      head      <= '0;
      tail      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        row_idx_d <= row_idx;
        last_d    <= final_rd;
      end
      if ((state == IDLE) && start) begin
        row_idx  <= '0;
        line_cnt <= '0;
      end else if (issue) begin
        if (row_idx == ROW_W'(Wh - 1)) begin
          row_idx  <= '0;
          line_cnt <= final_rd ? '0 : line_cnt + LINE_W'(1);
        end else begin
          row_idx <= row_idx + ROW_W'(1);
        end
      end
      occ <= occ_nxt;
      // Capture goes to the head when the skid is empty or the head leaves now
      if (inflight) begin
        if (pop || (occ == 2'd0)) head <= cap;
        else                      tail <= cap;
      end else if (pop) begin
        head <= tail;
      end
    end
  end

  assign out_data     = head.data;
  assign out_row      = head.row;
  assign out_last     = head.last;
  assign out_valid    = (occ != 2'd0);
  assign pe2row_ready = (state == RUN);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_conv_row_read_ctrl.sv
// Scoreboard bench for conv_row_read_ctrl: expected beats are queued when a
// frame starts; a negedge monitor pops and compares every accepted beat and
// also evaluates the directed checks queued by the stimulus process.
module tb_conv_row_read_ctrl;

  localparam int DW    = 8;
  localparam int WH    = 2;
  localparam int IW    = 7;
  localparam int FL    = 23;
  localparam int VW    = IW * DW;
  localparam int BEATS = WH * FL;

  typedef struct packed {
    logic [VW-1:0] data;
    logic          row;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WH-1:0]     rden;
  logic              pe2row_ready;
  logic [WH*VW-1:0]  dataout = '0;
  logic              valid;
  logic [VW-1:0]     out_data;
  logic [0:0]        out_row;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  conv_row_read_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .pe2row_fifo_array1_rden(rden), .pe2row_ready(pe2row_ready),
    .fifo_array1_dataout(dataout), .pe2row_data_valid(valid),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Vector content of FIFO row r for a given line of a frame
  function automatic logic [VW-1:0] vec(input int s, input int line, input int r);
    logic [VW-1:0] v;
    for (int e = 0; e < IW; e++) v[e*DW +: DW] = 8'(s * 37 + line * 11 + r * 5 + e);
    return v;
  endfunction

  // PE FIFO array model: one-cycle read latency, one line pointer per row
  int   seed = 0;
  logic model_clr = 1'b0;
  int   ptr [WH];
  always @(posedge clk) begin
    if (model_clr) begin
      for (int r = 0; r < WH; r++) ptr[r] <= 0;
    end else begin
      for (int r = 0; r < WH; r++)
        if (rden[r]) begin
          dataout[r*VW +: VW] <= vec(seed, ptr[r], r);
          ptr[r] <= ptr[r] + 1;
        end
    end
  end

  beat_t       exp_q[$];
  string       cname_q[$];
  logic [63:0] cact_q[$];
  logic [63:0] cexp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rd_total = 0, pop_total = 0, done_total = 0;
  int last_rd_cyc = 0, done_cyc = 0;

  logic          stall_prev = 1'b0;
  logic [VW-1:0] prev_data;
  logic          prev_row, prev_last;

  // Monitor: scoreboard pops, stream rules and queued directed checks
  always @(negedge clk) begin
    beat_t       e;
    string       nm;
    logic [63:0] a, x;
    while (cname_q.size() > 0) begin
      nm = cname_q.pop_front();
      a  = cact_q.pop_front();
      x  = cexp_q.pop_front();
      n_cmp++;
      if (a !== x) begin
        n_bad++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, x, cyc);
      end
    end
    if (rst !== 1'b0) begin
      stall_prev = 1'b0;
    end else begin
      if (rden != '0) begin
        rd_total++;
        last_rd_cyc = cyc;
        n_cmp++;
        if (!valid || !$onehot(rden)) begin
          n_bad++;
          $display("FAIL rden_rule: rden=%b valid=%b cycle %0d", rden, valid, cyc);
        end
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
      end
      if (stall_prev) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_row !== prev_row ||
            out_last !== prev_last) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%b %h/%0d/%0d expected 1 %h/%0d/%0d cycle %0d",
                   out_valid, out_data, out_row, out_last, prev_data, prev_row, prev_last, cyc);
        end
      end
      if (out_valid && out_ready) begin
        pop_total++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL beat_extra: got %h row %0d last %0d, expected no beat", out_data, out_row, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_row !== e.row || out_last !== e.last) begin
            n_bad++;
            $display("FAIL beat: got %h row %0d last %0d, expected %h row %0d last %0d",
                     out_data, out_row, out_last, e.data, e.row, e.last);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_row   = out_row[0];
      prev_last  = out_last;
    end
  end

  int rd_base, pop_base, done_base, start_cyc;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    cname_q.push_back(n);
    cact_q.push_back(a);
    cexp_q.push_back(x);
  endtask

  task automatic begin_frame(input int s);
    beat_t b;
    seed = s;
    for (int l = 0; l < FL; l++)
      for (int r = 0; r < WH; r++) begin
        b.data = vec(s, l, r);
        b.row  = r[0];
        b.last = (l == FL - 1) && (r == WH - 1);
        exp_q.push_back(b);
      end
    rd_base   = rd_total;
    pop_base  = pop_total;
    done_base = done_total;
    start_cyc = cyc;
    model_clr = 1'b1;
    start     = 1'b1;
    step();
    model_clr = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_total == done_base && k < budget) begin
      step();
      k++;
    end
    chk("done_seen", 64'(done_total > done_base), 64'd1);
  endtask

  task automatic end_checks();
    chk("beats", 64'(pop_total - pop_base), 64'(BEATS));
    chk("rden_pulses", 64'(rd_total - rd_base), 64'(BEATS));
    chk("done_pulses", 64'(done_total - done_base), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("done_after", 64'(done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, k;
    rst = 1'b1; start = 1'b0; valid = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_rden", 64'(rden), 64'd0);
    chk("rst_ready", 64'(pe2row_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_row", 64'(out_row), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();

    // Frame 1: free-running stream
    valid = 1'b1; out_ready = 1'b1;
    begin_frame(1);
    chk("first_rden", 64'(rden), 64'd1);
    chk("first_ready", 64'(pe2row_ready), 64'd1);
    chk("first_busy", 64'(busy), 64'd1);
    wait_done(200);
    chk("done_after_last_rd", 64'(done_cyc - last_rd_cyc), 64'd3);
    chk("frame_length", 64'(done_cyc - start_cyc), 64'(BEATS + 3));
    end_checks();

    // Frame 2: drain the pipe, then stall with data available
    begin_frame(2);
    repeat (14) step();
    valid = 1'b0;
    repeat (4) step();
    valid = 1'b1; out_ready = 1'b0;
    b = rd_total;
    repeat (10) step();
    chk("stall_rden", 64'(rd_total - b), 64'd2);
    chk("stall_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_done(300);
    end_checks();

    // Frame 3: pe2row_data_valid toggling every 3 cycles
    begin_frame(4);
    k = 0;
    while (done_total == done_base && k < 400) begin
      valid = ((k / 3) % 2) == 0;
      if (rd_total - rd_base < BEATS) chk("ready_in_run", 64'(pe2row_ready), 64'd1);
      step();
      k++;
    end
    chk("done_seen", 64'(done_total > done_base), 64'd1);
    end_checks();

    // Frame 4: reset with a full skid buffer, then a complete frame
    valid = 1'b1; out_ready = 1'b1;
    begin_frame(5);
    k = 0;
    while (pop_total - pop_base < 20 && k < 100) begin
      step();
      k++;
    end
    out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    chk("mid_rst_rden", 64'(rden), 64'd0);
    chk("mid_rst_ready", 64'(pe2row_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_row", 64'(out_row), 64'd0);
    chk("mid_rst_out_last", 64'(out_last), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    out_ready = 1'b1;
    step();
    begin_frame(6);
    wait_done(200);
    end_checks();

    // Frame 5: start pulses during RUN and DRAIN are ignored
    begin_frame(7);
    repeat (10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (rd_total - rd_base < BEATS && k < 100) begin
      step();
      k++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100);
    end_checks();
    repeat (5) step();
    chk("done_once", 64'(done_total - done_base), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_row_read_ctrl.md
# conv_row_read_ctrl

Read scheduler between the PE output FIFO array and the row buffer of the last convolution stage. Drives the per-row FIFO read enables (`pe2row_fifo_array1_rden`) and `pe2row_ready`. Serialises the Wh parallel FIFO rows into one Iw-wide vector per beat on a valid/ready stream, using a 2-entry skid buffer. Counts output lines per frame and signals frame completion.

## Interface
- DATA_WIDTH, 8, element width
- Wh, 2, number of FIFO rows in the array
- Iw, 7, elements per row vector
- FRAME_LINES, 23, output lines per frame (one line = Wh beats)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a frame (ignored unless IDLE)
- pe2row_fifo_array1_rden  out  Wh  one-hot FIFO row read enable
- pe2row_ready  out  1  controller accepting PE data (high in RUN)
- fifo_array1_dataout  in  Wh*Iw*DATA_WIDTH  FIFO array read data, one cycle after rden
- pe2row_data_valid  in  1  all Wh FIFO rows hold at least one vector
- out_data  out  Iw*DATA_WIDTH  row vector to row buffer
- out_row  out  $clog2(Wh) (min 1)  FIFO row index of out_data
- out_last  out  1  last beat of frame
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start.
  - RUN→DRAIN when the final read (row Wh-1 of line FRAME_LINES-1) issues.
  - DRAIN→DONE when the skid buffer is empty and no read is in flight.
  - DONE→IDLE unconditionally after 1 cycle.
- Counters:
  - row_idx: 0..Wh-1, wraps to 0 and increments line_cnt.
  - line_cnt: 0..FRAME_LINES-1.
  - Both clear on entering RUN.
- Read issue condition, all required: state==RUN, pe2row_data_valid==1, and occ + inflight − pop < 2.
  - occ = skid entries (0..2).
  - inflight = read issued last cycle.
  - pop = out_valid & out_ready.
- When a read issues, rden has exactly bit row_idx set. Otherwise rden = 0.
- PE side holds pe2row_data_valid high until all Wh rows of the current vector are read. Valid is checked before every read.
- Capture: in the cycle after a read, slice [row_idx_d] of fifo_array1_dataout is written to the skid tail with out_row = row_idx_d. out_last = 1 if that read was the frame's final read.
- Skid buffer is FIFO-ordered, depth 2; out_* present the head entry.
- Simultaneous capture and pop at occ==2 cannot occur; the issue rule guarantees this. Simultaneous capture and pop at occ==1 leaves occ==1.
- pe2row_ready = (state==RUN).
- start while not IDLE is ignored.

## Timing
- Reset values: rden=0, pe2row_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0, busy=0, done=0. Counters, occ and inflight are 0; state is IDLE.
- Reset mid-frame returns to IDLE in the next cycle. Captures and skid contents are discarded.
- start at cycle t: state is RUN at t+1, and the first rden can assert at t+1.
- rden at t: FIFO data valid during t+1, out_valid high from t+2.
- Steady state with out_ready=1 and valid=1: one read and one beat per cycle.
- Backpressure (out_ready=0): at most 2 reads issue after the stall begins, then rden stays 0 until a pop.
- out_data, out_row and out_last hold stable while out_valid & !out_ready.
- done pulses in the cycle where state==DONE. busy falls in the cycle after that.
- Total beats per frame = Wh*FRAME_LINES. Exactly one beat carries out_last.

## Test plan
- Reset, then start, with valid=1 and out_ready=1 (Wh=2, FRAME_LINES=23) → rden alternates 01,10 for 46 cycles; out_row alternates 0,1; out_last only on beat 46; done pulses 3 cycles after the last rden.
- Data ordering → FIFO row r driven with vector {line,r,e}; each beat's out_data equals the row selected by the prior rden; no reorder or duplication across all 46 beats.
- out_ready=0 for 10 cycles mid-frame → exactly 2 extra rden pulses after the stall starts; out_data stable throughout; no beat lost after release.
- pe2row_data_valid toggled 1/0 every 3 cycles → rden only when valid=1; total beats still 46; pe2row_ready high for the whole of RUN.
- rst asserted at beat 20 with occ=2 → next cycle all outputs at reset values; a new start runs a full 46-beat frame.
- start pulsed during RUN and DRAIN → ignored; line count and beat count unaffected; done pulses exactly once.
